// File: rtl/alu_cmd_issuer.sv
// Command/response controller for the 4-bit combinational ALU: one operation in flight, fixed settle time.
// Optional ALU_CHAIN_EN adds cmd_chain, which feeds the previous result back in as operand A.
module alu_cmd_issuer #(
    parameter int DATA_W     = 4,
    parameter int SEL_W      = 3,
    parameter int SETTLE_CYC = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [DATA_W-1:0] cmd_a,
    input  logic [DATA_W-1:0] cmd_b,
    input  logic [SEL_W-1:0]  cmd_sel,
`ifdef ALU_CHAIN_EN
    input  logic              cmd_chain,
`endif
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [SEL_W-1:0]  alu_sel,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_carry,
    input  logic              alu_zero,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_result,
    output logic              rsp_carry,
    output logic              rsp_zero,
    output logic              busy
);

    localparam int CNT_W = (SETTLE_CYC < 1) ? 1 : $clog2(SETTLE_CYC + 1);

    if (SETTLE_CYC < 1) begin : g_bad_settle
        $error("alu_cmd_issuer: SETTLE_CYC must be >= 1");
    end

    typedef enum logic [1:0] {IDLE, SETTLE, RESP} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [DATA_W-1:0]  alu_a_q, alu_a_d;
    logic [DATA_W-1:0]  alu_b_q, alu_b_d;
    logic [SEL_W-1:0]   alu_sel_q, alu_sel_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]  rsp_result_q, rsp_result_d;
    logic               rsp_carry_q, rsp_carry_d;
    logic               rsp_zero_q, rsp_zero_d;
`ifdef ALU_CHAIN_EN
    logic [DATA_W-1:0]  acc_q, acc_d;
`endif

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_sel_d    = alu_sel_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_result_d = rsp_result_q;
        rsp_carry_d  = rsp_carry_q;
        rsp_zero_d   = rsp_zero_q;
`ifdef ALU_CHAIN_EN
        acc_d        = acc_q;
`endif
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
`ifdef ALU_CHAIN_EN
                    alu_a_d = cmd_chain ? acc_q : cmd_a;
`else
                    alu_a_d = cmd_a;
`endif
                    alu_b_d   = cmd_b;
                    alu_sel_d = cmd_sel;
                    count_d   = CNT_W'(SETTLE_CYC - 1);
                    state_d   = SETTLE;
                end
            end
            SETTLE: begin
                // count reaching zero marks the edge SETTLE_CYC cycles after accept
                if (count_q != '0) begin
                    count_d = count_q - CNT_W'(1);
                end else begin
                    rsp_result_d = alu_result;
                    rsp_carry_d  = alu_carry;
                    rsp_zero_d   = alu_zero;
                    rsp_valid_d  = 1'b1;
`ifdef ALU_CHAIN_EN
                    acc_d        = alu_result;
`endif
                    state_d      = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            count_q      <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_sel_q    <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_result_q <= '0;
            rsp_carry_q  <= 1'b0;
            rsp_zero_q   <= 1'b0;
`ifdef ALU_CHAIN_EN
            acc_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_sel_q    <= alu_sel_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_result_q <= rsp_result_d;
            rsp_carry_q  <= rsp_carry_d;
            rsp_zero_q   <= rsp_zero_d;
`ifdef ALU_CHAIN_EN
            acc_q        <= acc_d;
`endif
        end
    end

    assign cmd_ready  = (state_q == IDLE);
    assign busy       = (state_q != IDLE);
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_sel    = alu_sel_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_result = rsp_result_q;
    assign rsp_carry  = rsp_carry_q;
    assign rsp_zero   = rsp_zero_q;

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Bench for alu_cmd_issuer: two instances (SETTLE_CYC=1 and 3) driving a behavioural ALU, scoreboarded responses.
module tb_alu_cmd_issuer;

    localparam int DW = 4;
    localparam int SW = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          cmd_valid  [2];
    logic          cmd_ready  [2];
    logic [DW-1:0] cmd_a      [2];
    logic [DW-1:0] cmd_b      [2];
    logic [SW-1:0] cmd_sel    [2];
`ifdef ALU_CHAIN_EN
    logic          cmd_chain  [2];
`endif
    logic [DW-1:0] alu_a      [2];
    logic [DW-1:0] alu_b      [2];
    logic [SW-1:0] alu_sel    [2];
    logic [DW-1:0] alu_result [2];
    logic          alu_carry  [2];
    logic          alu_zero   [2];
    logic          rsp_valid  [2];
    logic          rsp_ready  [2];
    logic [DW-1:0] rsp_result [2];
    logic          rsp_carry  [2];
    logic          rsp_zero   [2];
    logic          busy       [2];
    logic          glitch     [2];

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [3:0] r;
        logic       c;
        logic       z;
    } exp_t;
    exp_t       sb[$];
    logic [3:0] acc_m [2];

    // Reference ALU: {carry, zero, result}; SUB carry is the borrow out
    function automatic logic [5:0] alu_f(input logic [3:0] a, input logic [3:0] b, input logic [2:0] sel);
        logic [4:0] t;
        logic [3:0] r;
        logic       c;
        t = '0;
        c = 1'b0;
        case (sel)
            3'd0: begin t = {1'b0, a} + {1'b0, b}; r = t[3:0]; c = t[4]; end
            3'd1: begin t = {1'b0, a} - {1'b0, b}; r = t[3:0]; c = t[4]; end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: r = ~a;
            3'd6: begin r = {a[2:0], 1'b0}; c = a[3]; end
            default: begin r = {1'b0, a[3:1]}; c = a[0]; end
        endcase
        return {c, (r == 4'd0), r};
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        logic [5:0] alu_out;
        assign alu_out       = glitch[g] ? 6'b11_1111 : alu_f(alu_a[g], alu_b[g], alu_sel[g]);
        assign alu_result[g] = alu_out[3:0];
        assign alu_zero[g]   = alu_out[4];
        assign alu_carry[g]  = alu_out[5];

        alu_cmd_issuer #(
            .DATA_W    (DW),
            .SEL_W     (SW),
            .SETTLE_CYC((g == 0) ? 1 : 3)
        ) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .cmd_valid (cmd_valid[g]),
            .cmd_ready (cmd_ready[g]),
            .cmd_a     (cmd_a[g]),
            .cmd_b     (cmd_b[g]),
            .cmd_sel   (cmd_sel[g]),
`ifdef ALU_CHAIN_EN
            .cmd_chain (cmd_chain[g]),
`endif
            .alu_a     (alu_a[g]),
            .alu_b     (alu_b[g]),
            .alu_sel   (alu_sel[g]),
            .alu_result(alu_result[g]),
            .alu_carry (alu_carry[g]),
            .alu_zero  (alu_zero[g]),
            .rsp_valid (rsp_valid[g]),
            .rsp_ready (rsp_ready[g]),
            .rsp_result(rsp_result[g]),
            .rsp_carry (rsp_carry[g]),
            .rsp_zero  (rsp_zero[g]),
            .busy      (busy[g])
        );
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int settle_of(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    task automatic chk_reset(input int i);
        chk("rst_cmd_ready",  int'(cmd_ready[i]),  1);
        chk("rst_busy",       int'(busy[i]),       0);
        chk("rst_rsp_valid",  int'(rsp_valid[i]),  0);
        chk("rst_alu_a",      int'(alu_a[i]),      0);
        chk("rst_alu_b",      int'(alu_b[i]),      0);
        chk("rst_alu_sel",    int'(alu_sel[i]),    0);
        chk("rst_rsp_result", int'(rsp_result[i]), 0);
        chk("rst_rsp_carry",  int'(rsp_carry[i]),  0);
        chk("rst_rsp_zero",   int'(rsp_zero[i]),   0);
    endtask

    task automatic drive_cmd(input int i, input logic [3:0] a, input logic [3:0] b,
                             input logic [2:0] sel, input bit chain);
        int n;
        cmd_valid[i] = 1'b1;
        cmd_a[i]     = a;
        cmd_b[i]     = b;
        cmd_sel[i]   = sel;
`ifdef ALU_CHAIN_EN
        cmd_chain[i] = chain;
`else
        if (chain) $display("chain requested without ALU_CHAIN_EN");
`endif
        n = 0;
        while (!cmd_ready[i] && n < 20) begin
            @(posedge clk); #1; n++;
        end
        chk("accept_wait", n, 0);
        @(posedge clk); #1;
        cmd_valid[i] = 1'b0;
`ifdef ALU_CHAIN_EN
        cmd_chain[i] = 1'b0;
`endif
    endtask

    task automatic do_op(input int i, input logic [3:0] a, input logic [3:0] b, input logic [2:0] sel,
                         input bit chain, input int hold, input bit glt);
        exp_t       e;
        logic [5:0] m;
        logic [3:0] a_eff;
        int         n;
        a_eff = chain ? acc_m[i] : a;
        m = alu_f(a_eff, b, sel);
        e.r = m[3:0];
        e.c = m[5];
        e.z = m[4];
        sb.push_back(e);
        drive_cmd(i, a, b, sel, chain);
        chk("alu_a",         int'(alu_a[i]),     int'(a_eff));
        chk("alu_b",         int'(alu_b[i]),     int'(b));
        chk("alu_sel",       int'(alu_sel[i]),   int'(sel));
        chk("busy_op",       int'(busy[i]),      1);
        chk("cmd_ready_op",  int'(cmd_ready[i]), 0);
        if (glt) glitch[i] = 1'b1;
        n = 0;
        while (!rsp_valid[i] && n < 20) begin
            @(posedge clk); #1; n++;
            if (n == settle_of(i) - 1) glitch[i] = 1'b0;
        end
        glitch[i] = 1'b0;
        chk("rsp_latency", n, settle_of(i));
        e = sb.pop_front();
        chk("rsp_result", int'(rsp_result[i]), int'(e.r));
        chk("rsp_carry",  int'(rsp_carry[i]),  int'(e.c));
        chk("rsp_zero",   int'(rsp_zero[i]),   int'(e.z));
        acc_m[i] = e.r;
        if (hold > 0) begin
            cmd_valid[i] = 1'b1;
            cmd_a[i]     = 4'hF;
            cmd_b[i]     = 4'hF;
            cmd_sel[i]   = 3'd5;
        end
        for (int k = 0; k < hold; k++) begin
            @(posedge clk); #1;
            chk("hold_valid",     int'(rsp_valid[i]),  1);
            chk("hold_result",    int'(rsp_result[i]), int'(e.r));
            chk("hold_zero",      int'(rsp_zero[i]),   int'(e.z));
            chk("hold_cmd_ready", int'(cmd_ready[i]),  0);
            chk("hold_alu_a",     int'(alu_a[i]),      int'(a_eff));
        end
        rsp_ready[i] = 1'b1;
        @(posedge clk); #1;
        rsp_ready[i] = 1'b0;
        chk("hs_rsp_valid", int'(rsp_valid[i]),  0);
        chk("hs_cmd_ready", int'(cmd_ready[i]),  1);
        chk("hs_alu_a",     int'(alu_a[i]),      int'(a_eff));
        chk("hs_alu_sel",   int'(alu_sel[i]),    int'(sel));
        chk("hs_result",    int'(rsp_result[i]), int'(e.r));
        cmd_valid[i] = 1'b0;
    endtask

    // Start an op, reset mid-flight (SETTLE or RESP), and confirm nothing is ever answered
    task automatic abandon(input int i, input bit wait_rsp);
        int n;
        int seen;
        drive_cmd(i, 4'h7, 4'h1, 3'd0, 1'b0);
        n = 0;
        if (wait_rsp) begin
            while (!rsp_valid[i] && n < 20) begin
                @(posedge clk); #1; n++;
            end
            chk("abandon_rsp_seen", int'(rsp_valid[i]), 1);
        end else begin
            @(posedge clk); #1;
            chk("abandon_in_settle", int'(busy[i]), 1);
        end
        rst_n = 1'b0;
        #2;
        chk_reset(0);
        chk_reset(1);
        acc_m[0] = '0;
        acc_m[1] = '0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            if (rsp_valid[i] || !cmd_ready[i]) seen++;
        end
        chk("abandon_quiet", seen, 0);
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            cmd_valid[i] = 1'b0;
            cmd_a[i]     = '0;
            cmd_b[i]     = '0;
            cmd_sel[i]   = '0;
            rsp_ready[i] = 1'b0;
            glitch[i]    = 1'b0;
            acc_m[i]     = '0;
`ifdef ALU_CHAIN_EN
            cmd_chain[i] = 1'b0;
`endif
        end
        repeat (2) @(posedge clk);
        #1;
        chk_reset(0);
        chk_reset(1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        do_op(0, 4'h9, 4'h8, 3'd0, 1'b0, 0, 1'b0);
        do_op(0, 4'h5, 4'h5, 3'd1, 1'b0, 5, 1'b0);
        do_op(0, 4'h2, 4'h5, 3'd1, 1'b0, 0, 1'b0);
        do_op(0, 4'hA, 4'h6, 3'd2, 1'b0, 1, 1'b0);
        do_op(0, 4'h9, 4'h0, 3'd6, 1'b0, 0, 1'b0);
        do_op(0, 4'h3, 4'h0, 3'd5, 1'b0, 0, 1'b0);

        do_op(1, 4'hC, 4'h0, 3'd7, 1'b0, 0, 1'b1);
        do_op(1, 4'h6, 4'h3, 3'd4, 1'b0, 2, 1'b1);

        abandon(0, 1'b1);
        abandon(1, 1'b0);
        do_op(1, 4'h2, 4'h3, 3'd0, 1'b0, 0, 1'b0);
        do_op(0, 4'hF, 4'h1, 3'd0, 1'b0, 0, 1'b0);

`ifdef ALU_CHAIN_EN
        do_op(0, 4'h3, 4'h4, 3'd0, 1'b0, 0, 1'b0);
        do_op(0, 4'h0, 4'h2, 3'd0, 1'b1, 0, 1'b0);
        do_op(1, 4'h8, 4'h8, 3'd0, 1'b0, 0, 1'b0);
        do_op(1, 4'h0, 4'h3, 3'd3, 1'b1, 0, 1'b0);
`endif

        chk("sb_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
